// File: rtl/riscpipe_pkg.sv
// Shared pipeline types for the LM/SM expansion logic.
package riscpipe_pkg;

   localparam int unsigned NREG = 8;

   typedef logic [2:0] rf_addr_t;

   typedef enum logic {SEQ_IDLE, SEQ_RUN} seq_state_e;

   typedef enum logic [1:0] {UOP_NONE, UOP_LOAD, UOP_STORE} uop_kind_e;

endpackage

// File: rtl/lm_sm_sequencer_if.sv
// ID/RF-side bundle of the LM/SM sequencer: instruction fields in, micro-ops and stalls out.
interface lm_sm_sequencer_if #(
   parameter int unsigned DW   = 16,
   parameter int unsigned NREG = riscpipe_pkg::NREG
);
   localparam int unsigned RW = $clog2(NREG);

   logic            id_valid;
   logic            id_is_lm;
   logic            id_is_sm;
   logic [NREG-1:0] id_mask;
   logic [DW-1:0]   id_base;
   logic            hold_in;
   logic            flush_in;
   logic            uop_valid;
   logic            uop_is_load;
   logic            uop_is_store;
   logic [RW-1:0]   uop_reg;
   logic [DW-1:0]   uop_addr;
   logic            uop_last;
   logic            seq_busy;
   logic            stall_pc;
   logic            stall_if_id;

   modport master (
      output id_valid, id_is_lm, id_is_sm, id_mask, id_base, hold_in, flush_in,
      input  uop_valid, uop_is_load, uop_is_store, uop_reg, uop_addr, uop_last,
             seq_busy, stall_pc, stall_if_id
   );

   modport slave (
      input  id_valid, id_is_lm, id_is_sm, id_mask, id_base, hold_in, flush_in,
      output uop_valid, uop_is_load, uop_is_store, uop_reg, uop_addr, uop_last,
             seq_busy, stall_pc, stall_if_id
   );

endinterface

// File: rtl/mask_prio_enc.sv
// Picks the lowest-numbered register in an LM/SM mask (MSB = R0) and clears it.
module mask_prio_enc #(
   parameter int unsigned NREG = riscpipe_pkg::NREG,
   localparam int unsigned RW  = $clog2(NREG)
) (
   input  logic [NREG-1:0] mask,
   output logic [RW-1:0]   idx,
   output logic            found,
   output logic [NREG-1:0] mask_next
);

   always_comb begin
      found     = 1'b0;
      idx       = '0;
      mask_next = mask;
      for (int i = 0; i < NREG; i++) begin
         if (!found && mask[NREG-1-i]) begin
            found                = 1'b1;
            idx                  = RW'(i);
            mask_next[NREG-1-i]  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/lm_sm_sequencer.sv
// Expands one LM/SM into per-register load/store micro-ops, stalling PC and IF/ID meanwhile.
module lm_sm_sequencer
   import riscpipe_pkg::*;
#(
   parameter int unsigned DW        = 16,
   parameter int unsigned NREG      = riscpipe_pkg::NREG,
   parameter int unsigned ADDR_STEP = 1
) (
   input logic               clk,
   input logic               rst_n,
   lm_sm_sequencer_if.slave  bus
);

   localparam int unsigned RW = $clog2(NREG);

   seq_state_e      state_q, state_d;
   logic [NREG-1:0] mask_q, mask_d;
   logic [DW-1:0]   addr_q, addr_d;
   uop_kind_e       op_q, op_d;
   uop_kind_e       kind_q, kind_d;
   logic            valid_q, valid_d;
   logic            last_q, last_d;
   logic [RW-1:0]   reg_q, reg_d;
   logic [DW-1:0]   uaddr_q, uaddr_d;
   logic            stall;
   logic            start;

   logic [RW-1:0]   idx;
   logic            found;
   logic [NREG-1:0] mask_next;

   mask_prio_enc #(
      .NREG (NREG)
   ) u_prio (
      .mask      (mask_q),
      .idx       (idx),
      .found     (found),
      .mask_next (mask_next)
   );

   assign start = (state_q == SEQ_IDLE) & bus.id_valid & (bus.id_is_lm | bus.id_is_sm) &
                  ~bus.hold_in & ~bus.flush_in;

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      addr_d  = addr_q;
      op_d    = op_q;
      kind_d  = kind_q;
      valid_d = valid_q;
      last_d  = last_q;
      reg_d   = reg_q;
      uaddr_d = uaddr_q;
      stall   = 1'b0;

      if (bus.flush_in) begin
         state_d = SEQ_IDLE;
         mask_d  = '0;
         valid_d = 1'b0;
         kind_d  = UOP_NONE;
         last_d  = 1'b0;
      end else begin
         unique case (state_q)
            SEQ_IDLE: begin
               valid_d = 1'b0;
               kind_d  = UOP_NONE;
               last_d  = 1'b0;
               // An empty mask retires as a NOP without ever stalling.
               if (start && (|bus.id_mask)) begin
                  mask_d  = bus.id_mask;
                  addr_d  = bus.id_base;
                  op_d    = bus.id_is_lm ? UOP_LOAD : UOP_STORE;
                  state_d = SEQ_RUN;
                  stall   = 1'b1;
               end
            end
            SEQ_RUN: begin
               if (bus.hold_in) begin
                  stall = 1'b1;
               end else begin
                  valid_d = found;
                  reg_d   = idx;
                  uaddr_d = addr_q;
                  kind_d  = op_q;
                  last_d  = ~|mask_next;
                  mask_d  = mask_next;
                  addr_d  = addr_q + DW'(ADDR_STEP);
                  // Release the front end on the final issue so the next instruction moves up.
                  if (|mask_next) stall = 1'b1;
                  else            state_d = SEQ_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEQ_IDLE;
         mask_q  <= '0;
         addr_q  <= '0;
         op_q    <= UOP_NONE;
         kind_q  <= UOP_NONE;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         reg_q   <= '0;
         uaddr_q <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
         kind_q  <= kind_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         reg_q   <= reg_d;
         uaddr_q <= uaddr_d;
      end
   end

   assign bus.uop_valid    = valid_q;
   assign bus.uop_is_load  = (kind_q == UOP_LOAD);
   assign bus.uop_is_store = (kind_q == UOP_STORE);
   assign bus.uop_reg      = reg_q;
   assign bus.uop_addr     = uaddr_q;
   assign bus.uop_last     = last_q;
   assign bus.seq_busy     = (state_q == SEQ_RUN);
   assign bus.stall_pc     = stall;
   assign bus.stall_if_id  = stall;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Bench for lm_sm_sequencer: directed LM/SM scenarios plus random traffic vs. a queue model.
module tb_lm_sm_sequencer;
   import riscpipe_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   lm_sm_sequencer_if #(.DW(16), .NREG(8)) bus ();

   lm_sm_sequencer #(
      .DW        (16),
      .NREG      (8),
      .ADDR_STEP (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Model: pending (register, address) pairs of the sequence in flight.
   bit          m_busy;
   bit          m_load;
   int          q_reg[$];
   logic [15:0] q_addr[$];
   bit          e_valid, e_load, e_store, e_last;
   rf_addr_t    e_reg;
   logic [15:0] e_addr;

   always @(negedge clk)
      assert (!(bus.id_is_lm && bus.id_is_sm)) else $error("illegal LM+SM encoding driven");

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_load = 0;
      q_reg.delete(); q_addr.delete();
      e_valid = 0; e_load = 0; e_store = 0; e_last = 0; e_reg = '0; e_addr = '0;
   endtask

   task automatic set_in(bit v, bit lm, bit sm, logic [7:0] mask, logic [15:0] base,
                         bit hold, bit flush);
      bus.id_valid = v; bus.id_is_lm = lm; bus.id_is_sm = sm; bus.id_mask = mask;
      bus.id_base = base; bus.hold_in = hold; bus.flush_in = flush;
   endtask

   // One clock: checks stalls before the edge, uop outputs after it.
   task automatic cycle(output bit st, output bit iss);
      bit start, e_st, hold_now;
      logic [15:0] a;
      #2;
      start = !m_busy && bus.id_valid && (bus.id_is_lm || bus.id_is_sm) &&
              !bus.hold_in && !bus.flush_in;
      if (bus.flush_in)  e_st = 0;
      else if (m_busy)   e_st = bus.hold_in || (q_reg.size() > 1);
      else               e_st = start && (bus.id_mask != 0);
      st = bus.stall_pc;
      check_eq("stall_pc", 32'(bus.stall_pc), 32'(e_st));
      check_eq("stall_if_id", 32'(bus.stall_if_id), 32'(e_st));
      check_eq("seq_busy", 32'(bus.seq_busy), 32'(m_busy));
      hold_now = bus.hold_in;

      if (bus.flush_in) begin
         m_busy = 0; q_reg.delete(); q_addr.delete();
         e_valid = 0; e_load = 0; e_store = 0; e_last = 0;
      end else if (!m_busy) begin
         e_valid = 0; e_load = 0; e_store = 0; e_last = 0;
         if (start && bus.id_mask != 0) begin
            a = bus.id_base;
            for (int r = 0; r < 8; r++)
               if (bus.id_mask[7-r]) begin
                  q_reg.push_back(r); q_addr.push_back(a); a = a + 16'd1;
               end
            m_busy = 1; m_load = bus.id_is_lm;
         end
      end else if (!bus.hold_in) begin
         e_valid = 1; e_reg = rf_addr_t'(q_reg.pop_front()); e_addr = q_addr.pop_front();
         e_load = m_load; e_store = !m_load; e_last = (q_reg.size() == 0);
         if (q_reg.size() == 0) m_busy = 0;
      end

      @(posedge clk); #1;
      check_eq("uop_valid", 32'(bus.uop_valid), 32'(e_valid));
      check_eq("uop_is_load", 32'(bus.uop_is_load), 32'(e_load));
      check_eq("uop_is_store", 32'(bus.uop_is_store), 32'(e_store));
      if (e_valid) begin
         check_eq("uop_reg", 32'(bus.uop_reg), 32'(e_reg));
         check_eq("uop_addr", 32'(bus.uop_addr), 32'(e_addr));
         check_eq("uop_last", 32'(bus.uop_last), 32'(e_last));
      end
      iss = bus.uop_valid && !hold_now;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bit st, iss;
      set_in(0, 0, 0, 8'h00, 16'h0000, 0, 0);
      for (int i = 0; i < n; i++) cycle(st, iss);
   endtask

   // Presents one LM/SM until it retires (stall_pc low before an edge), counting stalls and uops.
   task automatic run_seq(input bit lm, input logic [7:0] mask, input logic [15:0] base,
                          input int hold_after, input int hold_len, input int flush_after,
                          output int stalls, output int uops);
      bit st, iss, done;
      int held;
      stalls = 0; uops = 0; held = 0; done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         set_in(1, lm, !lm, mask, base, 0, 0);
         if (uops == hold_after && held < hold_len) begin bus.hold_in = 1; held++; end
         if (uops == flush_after) bus.flush_in = 1;
         cycle(st, iss);
         if (st) stalls++;
         if (iss) uops++;
         if (!st) done = 1;
      end
      check_eq("seq_retired", 32'(done), 32'd1);
      set_in(0, 0, 0, 8'h00, 16'h0000, 0, 0);
   endtask

   initial begin
      int  stalls, uops;
      bit  st, iss;
      model_reset();
      set_in(0, 0, 0, 8'h00, 16'h0000, 0, 0);
      #3;
      check_eq("rst_uop_valid", 32'(bus.uop_valid), 32'd0);
      check_eq("rst_uop_addr", 32'(bus.uop_addr), 32'd0);
      check_eq("rst_stall_pc", 32'(bus.stall_pc), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      idle(2);

      run_seq(1, 8'b1010_0000, 16'h0100, -1, 0, -1, stalls, uops);
      check_eq("lm2_stalls", 32'(stalls), 32'd2);
      check_eq("lm2_uops", 32'(uops), 32'd2);
      check_eq("lm2_last_reg", 32'(bus.uop_reg), 32'd2);
      check_eq("lm2_last_addr", 32'(bus.uop_addr), 32'h0101);
      check_eq("lm2_last_flag", 32'(bus.uop_last), 32'd1);
      idle(2);

      run_seq(1, 8'h00, 16'h0300, -1, 0, -1, stalls, uops);
      check_eq("lm0_stalls", 32'(stalls), 32'd0);
      check_eq("lm0_uops", 32'(uops), 32'd0);
      run_seq(0, 8'h00, 16'h0300, -1, 0, -1, stalls, uops);
      check_eq("sm0_stalls", 32'(stalls), 32'd0);
      idle(2);

      run_seq(0, 8'hFF, 16'h0200, 3, 3, -1, stalls, uops);
      check_eq("smff_stalls", 32'(stalls), 32'd11);
      check_eq("smff_uops", 32'(uops), 32'd8);
      check_eq("smff_last_addr", 32'(bus.uop_addr), 32'h0207);
      idle(2);

      run_seq(1, 8'hF0, 16'h0400, -1, 0, 2, stalls, uops);
      check_eq("flush_uops", 32'(uops), 32'd2);
      check_eq("flush_valid", 32'(bus.uop_valid), 32'd0);
      check_eq("flush_busy", 32'(bus.seq_busy), 32'd0);
      idle(3);

      run_seq(0, 8'b0000_0011, 16'hFFFF, -1, 0, -1, stalls, uops);
      check_eq("wrap_uops", 32'(uops), 32'd2);
      check_eq("wrap_reg", 32'(bus.uop_reg), 32'd7);
      check_eq("wrap_addr", 32'(bus.uop_addr), 32'h0000);
      idle(2);

      // Asynchronous reset in the middle of a running sequence.
      set_in(1, 1, 0, 8'hFF, 16'h0500, 0, 0);
      for (int i = 0; i < 3; i++) cycle(st, iss);
      set_in(0, 0, 0, 8'h00, 16'h0000, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_valid", 32'(bus.uop_valid), 32'd0);
      check_eq("arst_busy", 32'(bus.seq_busy), 32'd0);
      check_eq("arst_stall", 32'(bus.stall_pc), 32'd0);
      check_eq("arst_addr", 32'(bus.uop_addr), 32'd0);
      check_eq("arst_reg", 32'(bus.uop_reg), 32'd0);
      model_reset();
      @(negedge clk); rst_n = 1'b1;
      idle(2);
      run_seq(1, 8'b0100_0001, 16'h0600, -1, 0, -1, stalls, uops);
      check_eq("post_rst_uops", 32'(uops), 32'd2);
      idle(2);

      for (int i = 0; i < 500; i++) begin
         bit lm;
         lm = $urandom_range(0, 1) == 1;
         set_in($urandom_range(0, 3) != 0, lm, !lm,
                ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                ($urandom_range(0, 3) == 0) ? 16'hFFFC : 16'($urandom),
                $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0);
         cycle(st, iss);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
